// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and defaults for the interrupt controller
package irq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } irq_state_e;

    localparam logic [7:0] DEF_VEC_BASE = 8'h20;
    localparam logic [7:0] DEF_NMI_VEC  = 8'h02;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-first priority encoder with valid flag
module irq_prio_enc #(
    parameter int W     = 8,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     i_req,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - masked, prioritised, nesting interrupt controller with NMI
module irq_controller
    import irq_pkg::*;
#(
    parameter int                   NUM_IRQ   = 8,
    parameter logic [NUM_IRQ-1:0]   EDGE_MASK = NUM_IRQ'(8'h0F),
    parameter int                   VEC_W     = 8,
    parameter logic [VEC_W-1:0]     VEC_BASE  = VEC_W'(DEF_VEC_BASE),
    parameter logic [VEC_W-1:0]     NMI_VEC   = VEC_W'(DEF_NMI_VEC)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic               i_nmi,
    input  logic               i_int_disable,
    input  logic               i_mask_we,
    input  logic [NUM_IRQ-1:0] i_mask_wdata,
    output logic               o_int,
    output logic [VEC_W-1:0]   o_vector,
    input  logic               i_ina,
    input  logic               i_eoi,
    output logic [NUM_IRQ:0]   o_isr
);

    // Encoder source order: index 0 is NMI, index k+1 is line k.
    localparam int SRC_W = NUM_IRQ + 1;
    localparam int IDX_W = $clog2(SRC_W);

    irq_state_e         r_state;
    logic [NUM_IRQ-1:0] r_pend;
    logic               r_nmi_pend;
    logic [NUM_IRQ-1:0] r_irq_d;
    logic               r_nmi_d;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ:0]   r_isr;
    logic [IDX_W-1:0]   r_win;
    logic [VEC_W-1:0]   r_vec;

    logic [NUM_IRQ-1:0] w_line_elig;
    logic [SRC_W-1:0]   w_elig_src;
    logic [SRC_W-1:0]   w_isr_src;
    logic               w_win_valid;
    logic [IDX_W-1:0]   w_win_idx;
    logic [VEC_W-1:0]   w_win_vec;
    logic               w_eoi_valid;
    logic [IDX_W-1:0]   w_eoi_idx;
    logic [NUM_IRQ:0]   w_eoi_clr;
    logic [NUM_IRQ:0]   w_ack_set;
    logic [NUM_IRQ-1:0] w_pend_nxt;
    logic               w_nmi_pend_nxt;

    // Maps an encoder source index back to a one-hot in isr bit layout.
    function automatic logic [NUM_IRQ:0] src_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_IRQ:0] oh;
        oh          = '0;
        oh[NUM_IRQ] = (idx == '0);
        for (int k = 0; k < NUM_IRQ; k++) begin
            oh[k] = (int'(idx) == k + 1);
        end
        return oh;
    endfunction

    // A line is blocked by any in-service entry of equal or higher priority, NMI included.
    always_comb begin
        logic blk;
        blk         = r_isr[NUM_IRQ];
        w_line_elig = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            blk            = blk | r_isr[k];
            w_line_elig[k] = r_pend[k] & ~r_mask[k] & ~i_int_disable & ~blk;
        end
    end

    assign w_elig_src = {w_line_elig, r_nmi_pend & ~r_isr[NUM_IRQ]};
    assign w_isr_src  = {r_isr[NUM_IRQ-1:0], r_isr[NUM_IRQ]};

    irq_prio_enc #(.W(SRC_W), .IDX_W(IDX_W)) u_win_enc (
        .i_req   (w_elig_src),
        .o_valid (w_win_valid),
        .o_idx   (w_win_idx)
    );

    irq_prio_enc #(.W(SRC_W), .IDX_W(IDX_W)) u_eoi_enc (
        .i_req   (w_isr_src),
        .o_valid (w_eoi_valid),
        .o_idx   (w_eoi_idx)
    );

    assign w_win_vec = (w_win_idx == '0) ? NMI_VEC
                     : VEC_W'(32'(VEC_BASE) + 32'(w_win_idx) - 32'd1);

    assign w_eoi_clr = (i_eoi && w_eoi_valid) ? src_onehot(w_eoi_idx) : '0;
    assign w_ack_set = (r_state == REQ && i_ina) ? src_onehot(r_win) : '0;

    // Edge lines latch until acknowledged; level lines simply follow the input.
    assign w_pend_nxt = (EDGE_MASK & ((r_pend & ~w_ack_set[NUM_IRQ-1:0]) | (i_irq & ~r_irq_d)))
                      | (~EDGE_MASK & i_irq);
    assign w_nmi_pend_nxt = (r_nmi_pend & ~w_ack_set[NUM_IRQ]) | (i_nmi & ~r_nmi_d);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_pend     <= '0;
            r_nmi_pend <= 1'b0;
            r_irq_d    <= '0;
            r_nmi_d    <= 1'b0;
            r_mask     <= '1;
            r_isr      <= '0;
            r_win      <= '0;
            r_vec      <= '0;
        end else begin
            r_irq_d    <= i_irq;
            r_nmi_d    <= i_nmi;
            r_pend     <= w_pend_nxt;
            r_nmi_pend <= w_nmi_pend_nxt;
            r_isr      <= (r_isr & ~w_eoi_clr) | w_ack_set;
            if (i_mask_we) begin
                r_mask <= i_mask_wdata;
            end
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_state <= REQ;
                        r_win   <= w_win_idx;
                        r_vec   <= w_win_vec;
                    end
                end
                REQ: begin
                    if (i_ina) begin
                        r_state <= IDLE;
                        r_vec   <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_int    = (r_state == REQ);
    assign o_vector = r_vec;
    assign o_isr    = r_isr;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - randomized and directed bench against a behavioural reference
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       rst_n, nmi, int_disable, mask_we, ina, eoi;
    logic [7:0] irq, mask_wdata;
    logic       o_int;
    logic [7:0] o_vector;
    logic [8:0] o_isr;

    int n_tests = 0;
    int n_fail  = 0;

    irq_controller dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_irq         (irq),
        .i_nmi         (nmi),
        .i_int_disable (int_disable),
        .i_mask_we     (mask_we),
        .i_mask_wdata  (mask_wdata),
        .o_int         (o_int),
        .o_vector      (o_vector),
        .i_ina         (ina),
        .i_eoi         (eoi),
        .o_isr         (o_isr)
    );

    always #5 clk = ~clk;

    logic [7:0] edge_cfg = 8'h0F;
    bit         m_pend[8];
    bit         m_irq_prev[8];
    bit         m_mask[8];
    bit         m_isr[9];
    bit         m_nmi_pend, m_nmi_prev, m_offer;
    int         m_id;
    logic [7:0] m_vec;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [8:0] model_isr();
        logic [8:0] v;
        for (int j = 0; j < 9; j++) v[j] = m_isr[j];
        return v;
    endfunction

    function automatic bit busy_at_or_above(input int line);
        if (m_isr[8]) return 1'b1;
        for (int j = 0; j <= line; j++) if (m_isr[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        int win   = -1;
        int acked = -1;
        if (!rst_n) begin
            foreach (m_pend[i]) begin
                m_pend[i] = 0; m_irq_prev[i] = 0; m_mask[i] = 1;
            end
            foreach (m_isr[i]) m_isr[i] = 0;
            m_nmi_pend = 0; m_nmi_prev = 0; m_offer = 0; m_id = 0; m_vec = 0;
            return;
        end
        if (!m_offer) begin
            if (m_nmi_pend && !m_isr[8]) win = 8;
            else begin
                for (int i = 0; i < 8; i++) begin
                    if (m_pend[i] && !m_mask[i] && !int_disable && !busy_at_or_above(i)) begin
                        win = i;
                        break;
                    end
                end
            end
        end
        if (eoi) begin
            if (m_isr[8]) m_isr[8] = 0;
            else begin
                for (int j = 0; j < 8; j++) if (m_isr[j]) begin m_isr[j] = 0; break; end
            end
        end
        if (m_offer && ina) begin
            m_isr[m_id] = 1; acked = m_id; m_offer = 0;
        end else if (!m_offer && win >= 0) begin
            m_offer = 1; m_id = win;
            m_vec = (win == 8) ? 8'h02 : 8'(8'h20 + win);
        end
        for (int i = 0; i < 8; i++) begin
            if (edge_cfg[i]) m_pend[i] = (m_pend[i] && acked != i) || (irq[i] && !m_irq_prev[i]);
            else             m_pend[i] = irq[i];
            m_irq_prev[i] = irq[i];
        end
        m_nmi_pend = (m_nmi_pend && acked != 8) || (nmi && !m_nmi_prev);
        m_nmi_prev = nmi;
        if (mask_we) for (int i = 0; i < 8; i++) m_mask[i] = mask_wdata[i];
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("int", o_int, m_offer);
        check("vector", o_vector, m_offer ? m_vec : 8'h00);
        check("isr", o_isr, model_isr());
    endtask

    task automatic pulse_ina();
        ina = 1; cycle(); ina = 0;
    endtask

    task automatic pulse_eoi();
        eoi = 1; cycle(); eoi = 0;
    endtask

    initial begin
        rst_n = 0; irq = 8'hFF; nmi = 0; int_disable = 0;
        mask_we = 0; mask_wdata = 0; ina = 0; eoi = 0;
        cycle(); cycle();
        check("rst_int", o_int, 0);
        check("rst_isr", o_isr, 9'h000);
        rst_n = 1; irq = 8'h00; cycle();

        irq = 8'h40; repeat (3) cycle();
        check("rst_mask_blocks", o_int, 0);
        irq = 8'h00; cycle();
        mask_we = 1; mask_wdata = 8'h00; cycle(); mask_we = 0;

        irq = 8'h08; cycle();
        check("lat_1cyc", o_int, 0);
        cycle();
        check("lat_2cyc", o_int, 1);
        check("vec_line3", o_vector, 8'h23);
        pulse_ina();
        check("ack3_int", o_int, 0);
        check("ack3_isr", o_isr, 9'h008);
        irq = 8'h00; pulse_eoi();
        check("eoi3_isr", o_isr, 9'h000);

        irq = 8'h24; cycle(); cycle();
        check("simul_first", o_vector, 8'h22);
        pulse_ina();
        check("simul_isr2", o_isr, 9'h004);
        pulse_eoi(); cycle();
        check("simul_second", o_vector, 8'h25);
        irq = 8'h00; pulse_ina(); pulse_eoi();

        irq = 8'h10; cycle(); cycle();
        irq = 8'h00; pulse_ina();
        check("nest_isr4", o_isr, 9'h010);
        irq = 8'h40; repeat (3) cycle();
        check("nest_lower_blocked", o_int, 0);
        irq = 8'h42; cycle(); cycle();
        check("nest_higher", o_vector, 8'h21);
        pulse_ina(); irq = 8'h00; pulse_eoi(); pulse_eoi();
        check("nest_cleared", o_isr, 9'h000);

        int_disable = 1; irq = 8'h01; nmi = 1; cycle(); cycle();
        check("nmi_vec", o_vector, 8'h02);
        pulse_ina();
        check("nmi_isr", o_isr, 9'h100);
        int_disable = 0; repeat (3) cycle();
        check("nmi_blocks_line0", o_int, 0);
        pulse_eoi(); cycle();
        check("line0_after_nmi", o_vector, 8'h20);
        pulse_ina(); pulse_eoi(); irq = 8'h00; nmi = 0; cycle();

        irq = 8'h80; cycle(); cycle();
        check("req_line7", o_vector, 8'h27);
        irq = 8'h81; pulse_ina();
        check("ack7_isr", o_isr, 9'h080);
        check("ack7_int", o_int, 0);
        cycle();
        check("preempt_line0", o_vector, 8'h20);
        rst_n = 0; cycle();
        check("abort_int", o_int, 0);
        check("abort_isr", o_isr, 9'h000);
        rst_n = 1; irq = 8'h00; cycle();
        mask_we = 1; mask_wdata = 8'h00; cycle(); mask_we = 0;

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 8; i++) if ($urandom_range(0, 9) == 0) irq[i] = ~irq[i];
            if ($urandom_range(0, 19) == 0) nmi = ~nmi;
            if ($urandom_range(0, 29) == 0) int_disable = ~int_disable;
            mask_we    = ($urandom_range(0, 39) == 0);
            mask_wdata = 8'($urandom & $urandom);
            ina        = o_int ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            eoi        = ($urandom_range(0, 7) == 0);
            rst_n      = ($urandom_range(0, 399) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
